// File: rtl/scope_sweep_ctrl.sv
// scope_sweep_ctrl: sequences one scope sweep (arm, trigger, capture frame, draw, holdoff)
module scope_sweep_ctrl #(
  parameter int DATA_W       = 14,
  parameter int ADDR_W       = 11,
  parameter int HOLDOFF_CYC  = 1000,
  parameter int AUTO_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              single,
  input  logic [1:0]        time_division,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              draw_finished,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              draw_reset,
  output logic              draw_enable,
  output logic              busy,
  output logic              auto_trig,
  output logic [2:0]        state
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    CAPTURE   = 3'd2,
    DRAW      = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;
  localparam int HW = $clog2(HOLDOFF_CYC + 1);
  localparam int TW = $clog2(AUTO_TIMEOUT + 2);
  state_t            state_q;
  logic              ss_q, prev_valid_q, wr_en_q, draw_reset_q, draw_enable_q, auto_trig_q;
  logic [1:0]        td_q, dec_q;
  logic [DATA_W-1:0] prev_q, wr_data_q;
  logic [ADDR_W-1:0] idx_q, wr_addr_q;
  logic [HW-1:0]     hcnt_q;
  logic [TW-1:0]     tcnt_q;
  logic              hit_d, timeout_d, hold_done_d, rearm_d;
  always_comb begin
    hit_d       = adc_valid && prev_valid_q &&
                  (trig_slope ? (prev_q >= trig_level && adc_data < trig_level)
                              : (prev_q < trig_level && adc_data >= trig_level));
    timeout_d   = (AUTO_TIMEOUT != 0) && (tcnt_q == TW'(AUTO_TIMEOUT - 1));
    hold_done_d = hcnt_q == HW'(HOLDOFF_CYC - 1);
    rearm_d     = run && !ss_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ss_q          <= 1'b0;
      prev_valid_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      draw_reset_q  <= 1'b0;
      draw_enable_q <= 1'b0;
      auto_trig_q   <= 1'b0;
      td_q          <= '0;
      dec_q         <= '0;
      prev_q        <= '0;
      wr_data_q     <= '0;
      idx_q         <= '0;
      wr_addr_q     <= '0;
      hcnt_q        <= '0;
      tcnt_q        <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      draw_reset_q <= 1'b0;
      case (state_q)
        IDLE: if (run || single) begin
          state_q      <= WAIT_TRIG;
          ss_q         <= single && !run;
          td_q         <= time_division;
          prev_valid_q <= 1'b0;
          tcnt_q       <= '0;
        end
        WAIT_TRIG: begin
          tcnt_q <= tcnt_q + 1'b1;
          if (adc_valid) begin
            prev_q       <= adc_data;
            prev_valid_q <= 1'b1;
          end
          if (hit_d) begin
            // the triggering sample itself is stored at address 0
            state_q     <= CAPTURE;
            auto_trig_q <= 1'b0;
            wr_en_q     <= 1'b1;
            wr_addr_q   <= '0;
            wr_data_q   <= adc_data;
            idx_q       <= ADDR_W'(1);
            dec_q       <= (td_q == 2'd0) ? 2'd0 : 2'd1;
          end else if (timeout_d) begin
            state_q     <= CAPTURE;
            auto_trig_q <= 1'b1;
            idx_q       <= '0;
            dec_q       <= 2'd0;
          end
        end
        CAPTURE: if (adc_valid) begin
          dec_q <= (dec_q == td_q) ? 2'd0 : dec_q + 2'd1;
          if (dec_q == 2'd0) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q;
            wr_data_q <= adc_data;
            idx_q     <= idx_q + 1'b1;
            if (&idx_q) begin
              state_q      <= DRAW;
              draw_reset_q <= 1'b1;
            end
          end
        end
        DRAW: if (draw_enable_q && draw_finished) begin
          state_q       <= HOLDOFF;
          draw_enable_q <= 1'b0;
          hcnt_q        <= '0;
        end else begin
          draw_enable_q <= 1'b1;
        end
        HOLDOFF: begin
          hcnt_q <= hcnt_q + 1'b1;
          if (hold_done_d) begin
            state_q      <= rearm_d ? WAIT_TRIG : IDLE;
            td_q         <= rearm_d ? time_division : td_q;
            prev_valid_q <= 1'b0;
            tcnt_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign draw_reset  = draw_reset_q;
  assign draw_enable = draw_enable_q;
  assign auto_trig   = auto_trig_q;
  assign busy        = state_q != IDLE;
  assign state       = state_q;
endmodule
